pong_text: RTL and testbench
============================

// Module: pong_text
// PURPOSE
//  Score/text overlay for the Pong display path; the direct consumer of font_rom.
//  Maps the current VGA pixel to a font_rom address, realigns the pixel pipeline to the
//  ROM's 1-cycle registered-address latency, and outputs text_on/text_rgb to the pixel mux.
//  Owns the 2-digit BCD score; shows "SCORE:DD" in the top 32 scan lines, glyphs scaled x2.
// PARAMETERS
//  RGB_W   12       width of colour outputs
//  FG_RGB  12'hFFF  text foreground colour
//  BG_RGB  12'h000  colour in text region where glyph bit is 0
// PORTS
//  clk         in   1      system clock; all state on rising edge
//  reset       in   1      synchronous, active-high reset
//  pixel_x     in   10     current pixel column from VGA sync
//  pixel_y     in   10     current pixel row from VGA sync
//  video_on    in   1      visible-area flag for current pixel
//  d_inc       in   1      1-cycle pulse: score +1 (BCD)
//  d_clr       in   1      1-cycle pulse: score := 00 (new game)
//  font_addr   out  11     {char_code[6:0], glyph_row[3:0]} to font_rom.addr
//  font_data   in   8      font_rom.data; bit7 = leftmost glyph pixel
//  score_bcd   out  8      {tens, ones} live score
//  text_on     out  1      text pixel lit (aligned to font_data)
//  text_rgb    out  RGB_W  colour for aligned pixel
// BEHAVIOUR
//  - Reset: score 00, display latch 00, all pipeline regs 0 -> text_on=0, text_rgb=0.
//  - Score: d_clr beats d_inc on the same cycle. d_inc: ones 9->0 carries into tens;
//    99 -> 00 wraps. score_bcd shows new value the cycle after the pulse.
//  - Display latch: disp_bcd <= score when pixel_x==0 && pixel_y==0, so a frame never tears.
//    A d_inc in the latch cycle latches the pre-increment value.
//  - Region: region = (pixel_y[9:5]==0) && (pixel_x[9:4] < 8). Char col = pixel_x[9:4];
//    glyph_row = pixel_y[4:1]; bit_col = pixel_x[3:1].
//  - Char codes, col 0..7: 'S'53 'C'43 'O'4F 'R'52 'E'45 ':'3A, 30+tens, 30+ones.
//    Outside region, char_code = 7'h00 (blank glyph).
//  - font_addr is combinational from pixel_x/pixel_y/disp_bcd, with no register,
//    because font_rom registers the address internally.
//  - Stage 1 regs, 1 clk: bit_col_d, region_d, video_on_d.
//    text_on = region_d & font_data[~bit_col_d].
//    text_rgb = !video_on_d ? 0 : (text_on ? FG_RGB : (region_d ? BG_RGB : 0)).
//  - Total latency: text_on/text_rgb describe the pixel presented 1 clk earlier.
//    The sync stage must delay hsync/vsync by 1 clk to match.
//  - Reset mid-frame: outputs drop to 0 next edge; first valid pixel 1 clk after release.
// STRUCTURE
//  - pong_pkg: ASCII char-code localparams, TEXT_ROWS=32, TEXT_COLS=8, RGB_W, screen dims.
//  - Sub-module bcd2_counter: clk, reset, inc, clr, bcd[7:0]; holds all carry/wrap logic.
//  - Top: address mux, frame latch, stage-1 alignment regs, colour mux.
//  - Bench instantiates the real font_rom, or a 1-cycle ROM model.
// TESTING
//  1. Assert reset 3 clks -> text_on=0, text_rgb=0, score_bcd=8'h00.
//  2. Apply 12 d_inc pulses -> score_bcd=8'h12. Then d_inc+d_clr together -> 8'h00.
//  3. Apply 99 d_inc -> 8'h99; one more -> 8'h00 (wrap).
//  4. Drive (x=0..15, y=2) with ROM data 8'h80 -> font_addr=11'h531;
//     text_on=1 only for x=0,1, seen 1 clk later; text_rgb=FG_RGB.
//  5. Drive y=32, or x>=128 -> text_on=0. Drive video_on=0 -> text_rgb=0 even if glyph bit set.
//  6. Score 05, then d_inc mid-frame at y=100 -> digit address stays {7'h35,row}
//     until next (0,0), then {7'h36,row}.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants for the Pong text overlay: character codes, text-region
// geometry, colour width and screen dimensions.
package pong_pkg;

    // Colour channel width used on the pixel mux path
    localparam int RGB_W = 12;

    // Visible screen size in pixels
    localparam logic [9:0] SCREEN_W = 10'd640;
    localparam logic [9:0] SCREEN_H = 10'd480;

    // Text band: top 32 scan lines, eight 16-pixel-wide character cells
    localparam logic [9:0] TEXT_ROWS = 10'd32;
    localparam logic [9:0] TEXT_COLS = 10'd8;

    // ASCII codes for the "SCORE:" banner; digits are CH_DIGIT0 + value
    localparam logic [6:0] CH_S      = 7'h53;
    localparam logic [6:0] CH_C      = 7'h43;
    localparam logic [6:0] CH_O      = 7'h4F;
    localparam logic [6:0] CH_R      = 7'h52;
    localparam logic [6:0] CH_E      = 7'h45;
    localparam logic [6:0] CH_COLON  = 7'h3A;
    localparam logic [6:0] CH_DIGIT0 = 7'h30;
    localparam logic [6:0] CH_BLANK  = 7'h00;

    // Character cell index within the text band
    typedef enum logic [2:0] {
        COL_S,
        COL_C,
        COL_O,
        COL_R,
        COL_E,
        COL_COLON,
        COL_TENS,
        COL_ONES
    } text_col_t;

    // ASCII code of a single BCD digit
    function automatic logic [6:0] digit_code(input logic [3:0] digit);
        return CH_DIGIT0 + {3'b000, digit};
    endfunction

endpackage

// File: rtl/pong_text_bcd2_counter.sv
// Two-digit BCD score counter: increments 00..99 with wrap, clear has priority.
module bcd2_counter
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] bcd
);

    logic [3:0] tens;
    logic [3:0] ones;

    // Score update: clear beats increment; ones carry into tens, 99 wraps to 00
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values, matching real flip-flop behaviour.
        if (reset || clr) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            if (ones == 4'd9) begin
                ones <= 4'd0;
                tens <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

    assign bcd = {tens, ones};

endmodule

// File: rtl/pong_text.sv
// Score/text overlay: maps the current pixel to a font_rom address, realigns the
// pixel attributes to the ROM's one-cycle latency and drives text_on/text_rgb.
module pong_text
    import pong_pkg::*;
#(
    parameter int                 RGB_W  = pong_pkg::RGB_W,
    parameter logic [RGB_W-1:0]   FG_RGB = 12'hFFF,
    parameter logic [RGB_W-1:0]   BG_RGB = 12'h000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic             video_on,
    input  logic             d_inc,
    input  logic             d_clr,
    output logic [10:0]      font_addr,
    input  logic [7:0]       font_data,
    output logic [7:0]       score_bcd,
    output logic             text_on,
    output logic [RGB_W-1:0] text_rgb
);

    logic [7:0] disp_bcd;
    logic       region;
    logic [2:0] char_col;
    logic [3:0] glyph_row;
    logic [2:0] bit_col;
    logic [6:0] char_code;

    logic [2:0] bit_col_d;
    logic       region_d;
    logic       video_on_d;

    // Glyphs are doubled, so the lowest coordinate bits never select anything
    logic unused_lsbs;
    assign unused_lsbs = pixel_x[0] ^ pixel_y[0];

    bcd2_counter u_score (
        .clk   (clk),
        .reset (reset),
        .inc   (d_inc),
        .clr   (d_clr),
        .bcd   (score_bcd)
    );

    // Pixel position decode: text band membership and cell/row/bit coordinates
    always_comb begin
        region    = (pixel_y < TEXT_ROWS) && (pixel_x[9:4] < TEXT_COLS[5:0])
                    && (pixel_x < SCREEN_W) && (pixel_y < SCREEN_H);
        char_col  = pixel_x[6:4];
        glyph_row = pixel_y[4:1];
        bit_col   = pixel_x[3:1];
    end

    // Character selection for the "SCORE:DD" banner, blank glyph elsewhere
    always_comb begin
        // NOTE: default first so every path assigns char_code and no latch is inferred.
        char_code = CH_BLANK;
        if (region) begin
            case (text_col_t'(char_col))
                COL_S:     char_code = CH_S;
                COL_C:     char_code = CH_C;
                COL_O:     char_code = CH_O;
                COL_R:     char_code = CH_R;
                COL_E:     char_code = CH_E;
                COL_COLON: char_code = CH_COLON;
                COL_TENS:  char_code = digit_code(disp_bcd[7:4]);
                COL_ONES:  char_code = digit_code(disp_bcd[3:0]);
                default:   char_code = CH_BLANK;
            endcase
        end
    end

    // The ROM registers the address itself, so the address leaves unregistered
    assign font_addr = {char_code, glyph_row};

    // Frame latch: capture the score at the first pixel so a frame never tears
    always_ff @(posedge clk) begin
        if (reset)
            disp_bcd <= 8'h00;
        else if (pixel_x == 10'd0 && pixel_y == 10'd0)
            disp_bcd <= score_bcd;
    end

    // Stage-1 alignment: delay pixel attributes to meet font_data
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_col_d  <= 3'd0;
            region_d   <= 1'b0;
            video_on_d <= 1'b0;
        end else begin
            bit_col_d  <= bit_col;
            region_d   <= region;
            video_on_d <= video_on;
        end
    end

    // Colour mux for the aligned pixel; bit 7 of a glyph row is its leftmost pixel
    always_comb begin
        text_on = region_d & font_data[~bit_col_d];
        if (!video_on_d)
            text_rgb = '0;
        else if (text_on)
            text_rgb = FG_RGB;
        else if (region_d)
            text_rgb = BG_RGB;
        else
            text_rgb = '0;
    end

endmodule

// File: tb/tb_pong_text.sv
// Self-checking bench for pong_text: directed steps plus randomized pixels and
// score pulses, compared against a string/arithmetic model of the overlay.
module tb_pong_text;

    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h0A5;

    logic        clk;
    logic        reset;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        d_inc;
    logic        d_clr;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [7:0]  score_bcd;
    logic        text_on;
    logic [11:0] text_rgb;

    int tests = 0;
    int fails = 0;

    // Behavioural state: live score and score shown this frame, both 0..99
    int model_score = 0;
    int model_disp  = 0;
    bit rom_const   = 1'b0;
    logic [10:0] last_addr;

    pong_text #(
        .RGB_W  (12),
        .FG_RGB (FG),
        .BG_RGB (BG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pixel_x   (pixel_x),
        .pixel_y   (pixel_y),
        .video_on  (video_on),
        .d_inc     (d_inc),
        .d_clr     (d_clr),
        .font_addr (font_addr),
        .font_data (font_data),
        .score_bcd (score_bcd),
        .text_on   (text_on),
        .text_rgb  (text_rgb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arbitrary but deterministic glyph contents
    function automatic logic [7:0] rom_fn(input logic [10:0] a);
        logic [15:0] t;
        t = 16'(a) * 16'd151 + 16'd29;
        return t[10:3] ^ a[7:0];
    endfunction

    // One-cycle registered-address ROM stand-in
    always @(posedge clk)
        font_data <= rom_const ? 8'h80 : rom_fn(font_addr);

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    // Text "SCORE:DD" spelled out by character position
    function automatic logic [6:0] model_char(input int x, input int y, input int d);
        if (y >= 32 || x >= 128) return 7'h00;
        case (x / 16)
            0: return 7'h53;
            1: return 7'h43;
            2: return 7'h4F;
            3: return 7'h52;
            4: return 7'h45;
            5: return 7'h3A;
            6: return 7'(48 + d / 10);
            default: return 7'(48 + d % 10);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one pixel for one clock and check address, aligned output and score
    task automatic step(input int x, input int y, input bit vo, input bit inc, input bit clr);
        logic [10:0] e_addr;
        logic [7:0]  glyph;
        bit          in_reg;
        bit          lit;
        logic [11:0] e_rgb;
        in_reg = (y < 32) && (x < 128);
        e_addr = {model_char(x, y, model_disp), 4'((y / 2) % 16)};
        glyph  = rom_const ? 8'h80 : rom_fn(e_addr);
        lit    = in_reg && glyph[7 - ((x / 2) % 8)];
        e_rgb  = !vo ? 12'h000 : (lit ? FG : (in_reg ? BG : 12'h000));
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = vo;
        d_inc    = inc;
        d_clr    = clr;
        #1;
        last_addr = font_addr;
        check("font_addr", 32'(font_addr), 32'(e_addr));
        if (x == 0 && y == 0) model_disp = model_score;
        if (clr) model_score = 0;
        else if (inc) model_score = (model_score + 1) % 100;
        @(posedge clk);
        #1;
        d_inc = 1'b0;
        d_clr = 1'b0;
        check("text_on", 32'(text_on), 32'(lit));
        check("text_rgb", 32'(text_rgb), 32'(e_rgb));
        check("score_bcd", 32'(score_bcd), 32'(to_bcd(model_score)));
    endtask

    initial begin
        int x;
        int y;
        reset    = 1'b1;
        pixel_x  = 10'd500;
        pixel_y  = 10'd300;
        video_on = 1'b1;
        d_inc    = 1'b0;
        d_clr    = 1'b0;

        // Reset for three clocks
        repeat (3) @(posedge clk);
        #1;
        check("rst_text_on", 32'(text_on), 32'd0);
        check("rst_text_rgb", 32'(text_rgb), 32'd0);
        check("rst_score", 32'(score_bcd), 32'h00);
        reset = 1'b0;
        model_score = 0;
        model_disp  = 0;

        // Twelve increments, then simultaneous inc+clr
        repeat (12) step(500, 300, 1'b1, 1'b1, 1'b0);
        check("score_12", 32'(score_bcd), 32'h12);
        step(500, 300, 1'b1, 1'b1, 1'b1);
        check("clr_beats_inc", 32'(score_bcd), 32'h00);

        // Count to 99, then wrap
        repeat (99) step(500, 300, 1'b1, 1'b1, 1'b0);
        check("score_99", 32'(score_bcd), 32'h99);
        step(500, 300, 1'b1, 1'b1, 1'b0);
        check("score_wrap", 32'(score_bcd), 32'h00);

        // First glyph row of 'S' with a single-pixel-wide ROM pattern
        rom_const = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(i, 2, 1'b1, 1'b0, 1'b0);
            if (i == 0) check("addr_531", 32'(last_addr), 32'h531);
            check("s_row_on", 32'(text_on), 32'(i < 2));
        end

        // Outside the band and blanked video
        step(0, 32, 1'b1, 1'b0, 1'b0);
        check("y32_off", 32'(text_on), 32'd0);
        step(128, 2, 1'b1, 1'b0, 1'b0);
        check("x128_off", 32'(text_on), 32'd0);
        step(0, 2, 1'b0, 1'b0, 1'b0);
        check("blank_rgb", 32'(text_rgb), 32'd0);

        // Reset mid-frame drops outputs next edge, valid again one clock after release
        step(0, 2, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_on", 32'(text_on), 32'd0);
        check("midrst_rgb", 32'(text_rgb), 32'd0);
        reset = 1'b0;
        model_score = 0;
        model_disp  = 0;
        step(0, 2, 1'b1, 1'b0, 1'b0);
        check("post_rst_on", 32'(text_on), 32'd1);

        // Score 05, latched at (0,0); mid-frame increment shows only next frame
        rom_const = 1'b0;
        repeat (5) step(500, 300, 1'b1, 1'b1, 1'b0);
        step(0, 0, 1'b1, 1'b0, 1'b0);
        step(112, 4, 1'b1, 1'b0, 1'b0);
        check("digit_05", 32'(last_addr), 32'h352);
        step(3, 100, 1'b1, 1'b1, 1'b0);
        step(112, 4, 1'b1, 1'b0, 1'b0);
        check("digit_held", 32'(last_addr), 32'h352);
        step(0, 0, 1'b1, 1'b0, 1'b0);
        step(112, 4, 1'b1, 1'b0, 1'b0);
        check("digit_06", 32'(last_addr), 32'h362);

        // Increment in the latch cycle captures the pre-increment value
        step(0, 0, 1'b1, 1'b1, 1'b0);
        step(112, 4, 1'b1, 1'b0, 1'b0);
        check("latch_pre_inc", 32'(last_addr), 32'h362);

        // Randomized pixels, blanking and score pulses
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                x = 0;
                y = 0;
            end else if ($urandom_range(0, 7) == 0) begin
                x = int'($urandom_range(0, 639));
                y = int'($urandom_range(0, 479));
            end else begin
                x = int'($urandom_range(0, 159));
                y = int'($urandom_range(0, 47));
            end
            step(x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 63) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
